bcd_down_timer: RTL
===================

# bcd_down_timer

Two-digit BCD countdown timer, the decrementing counterpart of the team's mod-10 up counter. It loads a preset value, counts down to 00 one step every TICK_DIV clocks, and pulses Done on expiry. Control is Start/Pause/Load. The block sits beside the up-counter in the lab timing datapath, and its BCD output drives the same display decoders.

## Interface
- TICK_DIV, default 1: number of Clk cycles per decrement while running. Legal range is 1..255. The prescaler is ceil(log2(TICK_DIV+1)) bits wide, with a minimum of 1 bit.
- Clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Load  in  1  loads LoadVal into the count and forces the IDLE state.
- LoadVal  in  8  preset value: [7:4] is the tens BCD digit, [3:0] is the ones BCD digit.
- Start  in  1  begins or resumes counting; level-sampled.
- Pause  in  1  suspends counting; level-sampled.
- CNT  out  8  current count: [7:4] tens, [3:0] ones. Always valid BCD.
- Run  out  1  high while the state is RUN.
- Done  out  1  one-cycle pulse when the count reaches 00 from the RUN state.

## Operation
- States:
  - IDLE: stopped; count is loaded or expired.
  - RUN: counting.
  - HOLD: paused mid-count.
- Priority at each edge: rst > Load > state transitions.
- rst: CNT=8'h00, Run=0, Done=0, state=IDLE, prescaler=0.
- Load, in any state:
  - CNT takes LoadVal. A digit greater than 9 is clamped to 9.
  - State goes to IDLE, prescaler goes to 0, Done=0.
  - Start or Pause in the same cycle is ignored.
- IDLE:
  - Start with CNT != 00: go to RUN and clear the prescaler.
  - Start with CNT == 00: ignored; no Run, no Done.
  - Pause: ignored.
- RUN:
  - Pause=1: go to HOLD. No decrement on that edge, and the prescaler holds. Pause wins over a coincident tick.
  - Otherwise the prescaler increments. When it equals TICK_DIV-1, it wraps to 0 and the count decrements.
  - Start is ignored.
- HOLD:
  - Start: go to RUN. The prescaler is not cleared, so the partial interval is preserved.
  - Pause: ignored.
  - Start and Pause together: RUN wins.
- Decrement (BCD):
  - Ones != 0: ones - 1.
  - Ones == 0: ones becomes 9 and tens - 1 (borrow).
- Expiry: the decrement that produces 00 also sets state to IDLE and Done=1 on the same edge. Done clears on the next edge. The count never decrements below 00 and never wraps to 99.
- Run is a registered output, equal to (state == RUN).

## Timing
- Start sampled at edge k from IDLE: decrements occur at edges k+TICK_DIV, k+2·TICK_DIV, and so on.
- Expiry latency from Start = N·TICK_DIV cycles, where N is the loaded value in decimal.
- Done is high for exactly one cycle, coincident with the first cycle in which CNT=00 and Run=0.
- Pause/resume: total RUN cycles to expiry remain N·TICK_DIV; HOLD cycles are excluded.
- rst or Load during RUN takes effect at that edge and produces no Done pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- TICK_DIV=1, Load 8'h12, then Start:
  - CNT steps 12, 11, 10, 09 … 01, 00 on consecutive edges.
  - Done=1 for exactly one cycle, 12 cycles after Start.
  - Run is 1 for 12 cycles and falls together with Done rising.
- Borrow and clamp:
  - Load 8'h20, Start: CNT goes to 8'h19 after one tick.
  - Load 8'hAF: CNT=8'h99.
  - Load 8'h00, Start: Run stays 0 and Done stays 0.
- Pause/resume, TICK_DIV=1:
  - Load 8'h05, Start, Pause once CNT=03: CNT holds 03 for 5 cycles with Run=0.
  - Start again: CNT reaches 00 three cycles later with a Done pulse.
- TICK_DIV=4, Load 8'h02, Start:
  - Decrements occur at +4 and +8 cycles.
  - Done pulses at +8.
  - Pause for 3 cycles at +2: Done moves to +11.
- Reset and reload mid-run:
  - rst at CNT=8'h07: CNT=00, Run=0, no Done.
  - Load 8'h30 while running: CNT=30, state IDLE, no Done.
  - Load with Start asserted in the same cycle: Start is ignored.

Source files
------------

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer: loads a preset, counts down to 00 one step per TICK_DIV clocks, pulses Done on expiry.
// Latency: all outputs registered; first decrement TICK_DIV edges after Start is sampled in IDLE.
// Backpressure: none; Pause suspends counting (HOLD keeps the partial prescaler interval), Start resumes.
//
// Ports:
//   Clk      clock, rising edge
//   rst      synchronous active-high reset
//   Load     load LoadVal (digits clamped to 9) and force IDLE; overrides Start/Pause
//   LoadVal  preset, [7:4] tens BCD, [3:0] ones BCD
//   Start    begin/resume counting (level)
//   Pause    suspend counting (level)
//   CNT      current count, always valid BCD
//   Run      high while counting
//   Done     one-cycle pulse when RUN reaches 00
module bcd_down_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       Load,
    input  logic [7:0] LoadVal,
    input  logic       Start,
    input  logic       Pause,
    output logic [7:0] CNT,
    output logic       Run,
    output logic       Done
);

    // Prescaler wide enough to hold TICK_DIV, never narrower than one bit.
    localparam int PW = ($clog2(TICK_DIV + 1) < 1) ? 1 : $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic [7:0]      cnt_q;
    logic            run_q;
    logic            done_q;

    logic [7:0]      load_d;
    logic [7:0]      dec_d;
    logic            tick_d;

    always_comb begin
        load_d = LoadVal;
        if (LoadVal[7:4] > 4'd9) load_d[7:4] = 4'd9;
        if (LoadVal[3:0] > 4'd9) load_d[3:0] = 4'd9;

        // BCD decrement with borrow from tens; never called at 00 (RUN leaves at expiry).
        if (cnt_q[3:0] != 4'd0) begin
            dec_d = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
        end else begin
            dec_d = {cnt_q[7:4] - 4'd1, 4'd9};
        end

        tick_d = (presc_q == PS_LAST);
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= 8'h00;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (Load) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= load_d;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // An expired/empty count cannot be started.
                    if (Start && (cnt_q != 8'h00)) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                        presc_q <= '0;
                    end
                end
                S_RUN: begin
                    // Pause beats a coincident tick: no decrement, prescaler frozen.
                    if (Pause) begin
                        state_q <= S_HOLD;
                        run_q   <= 1'b0;
                    end else if (tick_d) begin
                        presc_q <= '0;
                        cnt_q   <= dec_d;
                        if (dec_d == 8'h00) begin
                            state_q <= S_IDLE;
                            run_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Resume keeps the partial interval in the prescaler.
                    if (Start) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign CNT  = cnt_q;
    assign Run  = run_q;
    assign Done = done_q;

endmodule
